// File: rtl/uartlite_axi_responder_if.sv
// AXI4-lite register port plus the RX/TX byte streams of the UARTLite responder.
interface uartlite_axi_responder_if;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [1:0]  axi_bresp;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_awprot, axi_wvalid, axi_wdata, axi_wstrb,
           axi_bready, axi_arvalid, axi_araddr, axi_arprot, axi_rready,
           rx_valid, rx_data, tx_ready,
    output axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready,
           axi_rvalid, axi_rdata, axi_rresp, rx_ready, tx_valid, tx_data
  );

  modport master (
    output axi_awvalid, axi_awaddr, axi_awprot, axi_wvalid, axi_wdata, axi_wstrb,
           axi_bready, axi_arvalid, axi_araddr, axi_arprot, axi_rready,
           rx_valid, rx_data, tx_ready,
    input  axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_arready,
           axi_rvalid, axi_rdata, axi_rresp, rx_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/uartlite_axi_responder.sv
// UARTLite-compatible AXI4-lite responder: RX/TX byte FIFOs behind a four-register map.

// Byte FIFO with circular pointers, an occupancy counter and a synchronous clear.
module UartLiteFifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_clear,
  input  logic       i_push,
  input  logic [7:0] i_pushData,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_empty,
  output logic       o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(DEPTH));
  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~o_full | w_doPop);
  assign o_head   = r_mem[r_rdPtr];

  // Pointer and occupancy bookkeeping; clear takes priority over push/pop.
  always_ff @(posedge clk) begin
    if (!rstn || i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_doPush && !i_clear) r_mem[r_wrPtr] <= i_pushData;
  end
endmodule

module uartlite_axi_responder #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  uartlite_axi_responder_if.slave   bus
);
  typedef enum logic {W_IDLE, W_RESP} wState_t;
  typedef enum logic {R_IDLE, R_RESP} rState_t;

  wState_t     r_wState, w_wStateNext;
  rState_t     r_rState, w_rStateNext;
  logic        r_awHeld;
  logic        r_wHeld;
  logic [1:0]  r_wAddr;
  logic [7:0]  r_wData;
  logic [31:0] r_rdata;

  logic        w_awHs, w_wHs, w_arHs, w_doWrite;
  logic        w_rxPush, w_rxPop, w_rxClear, w_rxEmpty, w_rxFull;
  logic        w_txPush, w_txPop, w_txClear, w_txEmpty, w_txFull;
  logic [7:0]  w_rxHead, w_txHead;
  logic [31:0] w_stat, w_readValue;
  logic        w_unused;

  assign w_unused = ^{bus.axi_awaddr[31:4], bus.axi_awaddr[1:0], bus.axi_awprot,
                      bus.axi_wdata[31:8], bus.axi_wstrb,
                      bus.axi_araddr[31:4], bus.axi_araddr[1:0], bus.axi_arprot};

  // AXI channel outputs
  assign bus.axi_awready = ~r_awHeld & (r_wState == W_IDLE);
  assign bus.axi_wready  = ~r_wHeld & (r_wState == W_IDLE);
  assign bus.axi_bvalid  = (r_wState == W_RESP);
  assign bus.axi_bresp   = 2'b00;
  assign bus.axi_arready = (r_rState == R_IDLE);
  assign bus.axi_rvalid  = (r_rState == R_RESP);
  assign bus.axi_rdata   = r_rdata;
  assign bus.axi_rresp   = 2'b00;

  assign w_awHs = bus.axi_awvalid & bus.axi_awready;
  assign w_wHs  = bus.axi_wvalid & bus.axi_wready;
  assign w_arHs = bus.axi_arvalid & bus.axi_arready;

  // Byte stream side
  assign bus.rx_ready = ~w_rxFull;
  assign bus.tx_valid = ~w_txEmpty;
  assign bus.tx_data  = w_txHead;
  assign w_rxPush     = bus.rx_valid & ~w_rxFull;
  assign w_txPop      = bus.tx_ready & ~w_txEmpty;

  // Register-write side effects, all issued in the single cycle the write is performed.
  assign w_txPush  = w_doWrite & (r_wAddr == 2'd1);
  assign w_txClear = w_doWrite & (r_wAddr == 2'd3) & r_wData[0];
  assign w_rxClear = w_doWrite & (r_wAddr == 2'd3) & r_wData[1];
  assign w_rxPop   = w_arHs & (bus.axi_araddr[3:2] == 2'd0) & ~w_rxEmpty;

  assign w_stat = {28'b0, w_txFull, w_txEmpty, w_rxFull, ~w_rxEmpty};

  UartLiteFifo #(.DEPTH(FIFO_DEPTH)) u_rxFifo (
    .clk(clk), .rstn(rstn), .i_clear(w_rxClear), .i_push(w_rxPush),
    .i_pushData(bus.rx_data), .i_pop(w_rxPop), .o_head(w_rxHead),
    .o_empty(w_rxEmpty), .o_full(w_rxFull)
  );

  UartLiteFifo #(.DEPTH(FIFO_DEPTH)) u_txFifo (
    .clk(clk), .rstn(rstn), .i_clear(w_txClear), .i_push(w_txPush),
    .i_pushData(r_wData), .i_pop(w_txPop), .o_head(w_txHead),
    .o_empty(w_txEmpty), .o_full(w_txFull)
  );

  // Write FSM next state: perform the write once both address and data are held.
  always_comb begin
    w_wStateNext = r_wState;
    w_doWrite    = 1'b0;
    case (r_wState)
      W_IDLE: begin
        if (r_awHeld && r_wHeld) begin
          w_doWrite    = 1'b1;
          w_wStateNext = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.axi_bready) w_wStateNext = W_IDLE;
      end
      default: w_wStateNext = W_IDLE;
    endcase
  end

  // Write FSM state plus independent AW/W latches.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wState <= W_IDLE;
      r_awHeld <= 1'b0;
      r_wHeld  <= 1'b0;
      r_wAddr  <= 2'd0;
      r_wData  <= 8'd0;
    end else begin
      r_wState <= w_wStateNext;
      if (w_doWrite) begin
        r_awHeld <= 1'b0;
        r_wHeld  <= 1'b0;
      end else begin
        if (w_awHs) begin
          r_awHeld <= 1'b1;
          r_wAddr  <= bus.axi_awaddr[3:2];
        end
        if (w_wHs) begin
          r_wHeld <= 1'b1;
          r_wData <= bus.axi_wdata[7:0];
        end
      end
    end
  end

  // Read FSM next state: one response in flight, held until accepted.
  always_comb begin
    w_rStateNext = r_rState;
    case (r_rState)
      R_IDLE:  if (bus.axi_arvalid) w_rStateNext = R_RESP;
      R_RESP:  if (bus.axi_rready)  w_rStateNext = R_IDLE;
      default: w_rStateNext = R_IDLE;
    endcase
  end

  // Read data mux; an empty RX FIFO and the write-only registers read as zero.
  always_comb begin
    w_readValue = 32'd0;
    case (bus.axi_araddr[3:2])
      2'd0:    if (!w_rxEmpty) w_readValue = {24'b0, w_rxHead};
      2'd2:    w_readValue = w_stat;
      default: w_readValue = 32'd0;
    endcase
  end

  // Read FSM state and registered read data captured at the address handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rState <= R_IDLE;
      r_rdata  <= 32'd0;
    end else begin
      r_rState <= w_rStateNext;
      if (w_arHs) r_rdata <= w_readValue;
    end
  end
endmodule

// File: tb/tb_uartlite_axi_responder.sv
// Directed bench for uartlite_axi_responder with a queue-based model of both FIFOs.
module tb_uartlite_axi_responder;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   fails = 0;
  int   drained = 0;
  bit   checkEnable = 1'b0;
  logic [7:0]  rxQ[$];
  logic [7:0]  txQ[$];
  logic [31:0] got;

  always #5 clk = ~clk;

  uartlite_axi_responder_if bus();

  uartlite_axi_responder #(.FIFO_DEPTH(16)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] statModel();
    logic [31:0] s;
    s    = 32'd0;
    s[0] = (rxQ.size() != 0);
    s[1] = (rxQ.size() == 16);
    s[2] = (txQ.size() == 0);
    s[3] = (txQ.size() == 16);
    return s;
  endfunction

  function automatic logic [31:0] readModel(input logic [31:0] addr);
    if (addr[3:2] == 2'd0) return (rxQ.size() != 0) ? 32'(rxQ[0]) : 32'd0;
    if (addr[3:2] == 2'd2) return statModel();
    return 32'd0;
  endfunction

  // Advance one clock and land just after the edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rxPush(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    applyStimulus(1);
    bus.rx_valid = 1'b0;
    if (rxQ.size() < 16) rxQ.push_back(b);
  endtask

  task automatic txDrainOne();
    bus.tx_ready = 1'b1;
    applyStimulus(1);
    bus.tx_ready = 1'b0;
    if (txQ.size() != 0) begin
      void'(txQ.pop_front());
      drained++;
    end
  endtask

  task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input int wLead, input int bDelay);
    if (wLead > 0) begin
      bus.axi_wvalid = 1'b1;
      bus.axi_wdata  = data;
      checkOutput("wready_idle", 32'(bus.axi_wready), 32'd1);
      applyStimulus(1);
      bus.axi_wvalid = 1'b0;
      for (int i = 1; i < wLead; i++) begin
        checkOutput("wready_held", 32'(bus.axi_wready), 32'd0);
        checkOutput("bvalid_wait", 32'(bus.axi_bvalid), 32'd0);
        applyStimulus(1);
      end
      bus.axi_awvalid = 1'b1;
      bus.axi_awaddr  = addr;
      checkOutput("awready_idle", 32'(bus.axi_awready), 32'd1);
      applyStimulus(1);
      bus.axi_awvalid = 1'b0;
    end else begin
      bus.axi_awvalid = 1'b1;
      bus.axi_awaddr  = addr;
      bus.axi_wvalid  = 1'b1;
      bus.axi_wdata   = data;
      checkOutput("awready_idle", 32'(bus.axi_awready), 32'd1);
      checkOutput("wready_idle", 32'(bus.axi_wready), 32'd1);
      applyStimulus(1);
      bus.axi_awvalid = 1'b0;
      bus.axi_wvalid  = 1'b0;
    end
    checkOutput("bvalid_early", 32'(bus.axi_bvalid), 32'd0);
    applyStimulus(1);
    checkOutput("bvalid", 32'(bus.axi_bvalid), 32'd1);
    if (addr[3:2] == 2'd1 && txQ.size() < 16) txQ.push_back(data[7:0]);
    if (addr[3:2] == 2'd3 && data[0]) txQ.delete();
    if (addr[3:2] == 2'd3 && data[1]) rxQ.delete();
    for (int i = 0; i < bDelay; i++) begin
      applyStimulus(1);
      checkOutput("bvalid_hold", 32'(bus.axi_bvalid), 32'd1);
      checkOutput("awready_busy", 32'(bus.axi_awready), 32'd0);
      checkOutput("wready_busy", 32'(bus.axi_wready), 32'd0);
    end
    bus.axi_bready = 1'b1;
    applyStimulus(1);
    bus.axi_bready = 1'b0;
    checkOutput("bvalid_done", 32'(bus.axi_bvalid), 32'd0);
  endtask

  task automatic axiRead(input logic [31:0] addr, input int rDelay, output logic [31:0] data);
    logic [31:0] exp;
    exp = readModel(addr);
    bus.axi_arvalid = 1'b1;
    bus.axi_araddr  = addr;
    checkOutput("arready_idle", 32'(bus.axi_arready), 32'd1);
    applyStimulus(1);
    bus.axi_arvalid = 1'b0;
    if (addr[3:2] == 2'd0 && rxQ.size() != 0) void'(rxQ.pop_front());
    checkOutput("rvalid", 32'(bus.axi_rvalid), 32'd1);
    checkOutput("rdata", bus.axi_rdata, exp);
    data = bus.axi_rdata;
    for (int i = 0; i < rDelay; i++) begin
      applyStimulus(1);
      checkOutput("rvalid_hold", 32'(bus.axi_rvalid), 32'd1);
      checkOutput("rdata_hold", bus.axi_rdata, exp);
      checkOutput("arready_busy", 32'(bus.axi_arready), 32'd0);
    end
    bus.axi_rready = 1'b1;
    applyStimulus(1);
    bus.axi_rready = 1'b0;
    checkOutput("rvalid_done", 32'(bus.axi_rvalid), 32'd0);
  endtask

  // Every-cycle comparison of the stream side against the FIFO model.
  always @(negedge clk) begin
    if (checkEnable) begin
      checkOutput("rx_ready", 32'(bus.rx_ready), 32'(rxQ.size() < 16));
      checkOutput("tx_valid", 32'(bus.tx_valid), 32'(txQ.size() != 0));
      if (txQ.size() != 0) checkOutput("tx_data", 32'(bus.tx_data), 32'(txQ[0]));
      if (bus.axi_bvalid) checkOutput("bresp", 32'(bus.axi_bresp), 32'd0);
      if (bus.axi_rvalid) checkOutput("rresp", 32'(bus.axi_rresp), 32'd0);
    end
  end

  initial begin
    bus.axi_awvalid = 1'b0; bus.axi_awaddr = 32'd0; bus.axi_awprot = 3'd0;
    bus.axi_wvalid  = 1'b0; bus.axi_wdata  = 32'd0; bus.axi_wstrb  = 4'hF;
    bus.axi_bready  = 1'b0;
    bus.axi_arvalid = 1'b0; bus.axi_araddr = 32'd0; bus.axi_arprot = 3'd0;
    bus.axi_rready  = 1'b0;
    bus.rx_valid    = 1'b0; bus.rx_data = 8'd0;
    bus.tx_ready    = 1'b0;

    // Reset
    rstn = 1'b0;
    applyStimulus(2);
    checkOutput("reset_rvalid", 32'(bus.axi_rvalid), 32'd0);
    checkOutput("reset_bvalid", 32'(bus.axi_bvalid), 32'd0);
    checkOutput("reset_rdata", bus.axi_rdata, 32'd0);
    checkOutput("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    checkOutput("reset_rx_ready", 32'(bus.rx_ready), 32'd1);
    rstn = 1'b1;
    checkEnable = 1'b1;
    axiRead(32'h8, 0, got);
    checkOutput("stat_after_reset", got, 32'h4);

    // Single TX write with AW and W together
    axiWrite(32'h4, 32'h41, 0, 0);
    axiRead(32'h8, 0, got);
    checkOutput("stat_one_tx", got, 32'h0);
    checkOutput("tx_data_41", 32'(bus.tx_data), 32'h41);
    txDrainOne();
    axiRead(32'h8, 0, got);
    checkOutput("stat_tx_drained", got, 32'h4);

    // W leads AW by 3 cycles, response held 5 cycles
    axiWrite(32'h4, 32'h5A, 3, 5);
    checkOutput("tx_data_5a", 32'(bus.tx_data), 32'h5A);
    txDrainOne();

    // Writes to RX and STAT are ignored
    axiWrite(32'h0, 32'h55, 0, 0);
    axiWrite(32'h8, 32'hFF, 0, 1);
    axiRead(32'h8, 0, got);
    checkOutput("stat_ignored_writes", got, 32'h4);

    // RX fill, overflow attempt, drain past empty
    for (int i = 0; i < 17; i++) rxPush(8'(i));
    checkOutput("rx_ready_full", 32'(bus.rx_ready), 32'd0);
    axiRead(32'h8, 0, got);
    checkOutput("stat_rx_full", got, 32'h7);
    for (int i = 0; i < 17; i++) axiRead(32'h0, (i == 3) ? 2 : 0, got);
    checkOutput("rx_empty_read", got, 32'h0);
    axiRead(32'h8, 0, got);
    checkOutput("stat_rx_empty", got, 32'h4);

    // Second fill crossing the pointer wrap
    for (int i = 0; i < 10; i++) rxPush(8'h20 + 8'(i));
    for (int i = 0; i < 5; i++) axiRead(32'h0, 0, got);
    checkOutput("rx_wrap_fifth", got, 32'h24);
    for (int i = 0; i < 8; i++) rxPush(8'h30 + 8'(i));
    for (int i = 0; i < 13; i++) axiRead(32'h0, 0, got);
    checkOutput("rx_wrap_last", got, 32'h37);

    // TX overflow: 17 writes with the downstream stalled
    for (int i = 0; i < 16; i++) axiWrite(32'h4, 32'h60 + i, 0, 0);
    axiRead(32'h8, 0, got);
    checkOutput("stat_tx_full", got, 32'h8);
    axiWrite(32'h4, 32'h70, 0, 0);
    checkOutput("tx_head_after_drop", 32'(bus.tx_data), 32'h60);
    drained = 0;
    for (int i = 0; i < 17; i++) txDrainOne();
    checkOutput("tx_drained_count", 32'(drained), 32'd16);

    // Fill both, clear both through CTRL
    for (int i = 0; i < 16; i++) rxPush(8'h80 + 8'(i));
    for (int i = 0; i < 5; i++) axiWrite(32'h4, 32'h90 + i, 0, 0);
    axiWrite(32'hC, 32'h3, 0, 0);
    axiRead(32'h8, 0, got);
    checkOutput("stat_after_ctrl", got, 32'h4);

    // Reset while a read response is pending
    rxPush(8'h11);
    rxPush(8'h22);
    bus.axi_arvalid = 1'b1;
    bus.axi_araddr  = 32'h0;
    applyStimulus(1);
    bus.axi_arvalid = 1'b0;
    void'(rxQ.pop_front());
    checkOutput("midread_rvalid", 32'(bus.axi_rvalid), 32'd1);
    checkOutput("midread_rdata", bus.axi_rdata, 32'h11);
    rstn = 1'b0;
    applyStimulus(1);
    rxQ.delete();
    txQ.delete();
    checkOutput("midreset_rvalid", 32'(bus.axi_rvalid), 32'd0);
    rstn = 1'b1;
    axiRead(32'h8, 0, got);
    checkOutput("stat_after_midreset", got, 32'h4);

    checkEnable = 1'b0;
    applyStimulus(1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
